// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Purpose  : Shared constants, types and trellis helpers for the K=3,
//            rate-1/2 convolutional encoder and its Viterbi decoder.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  // Code parameters: constraint length, shift-register width, symbol width
  localparam int K          = 3;
  localparam int SR_W       = K - 1;
  localparam int SYM_W      = 2;
  localparam int NUM_STATES = 1 << SR_W;

  // Generator polynomials, MSB taps the newest (input) bit
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Trellis start/termination state
  localparam logic [SR_W-1:0] SR_ZERO = '0;

  // Encoder control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_TAIL1 = 2'd2,
    ST_TAIL2 = 2'd3
  } enc_state_t;

  // Branch output for one trellis transition: [1]=g0 parity, [0]=g1 parity.
  // The decoder BMU uses the same function to build its expected symbols.
  function automatic logic [SYM_W-1:0] branch_out(
    input logic            bit_in,
    input logic [SR_W-1:0] state
  );
    logic [K-1:0] taps;
    taps = {bit_in, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Successor state: the new bit enters at the top, the oldest bit falls out
  function automatic logic [SR_W-1:0] next_sr(
    input logic            bit_in,
    input logic [SR_W-1:0] state
  );
    return {bit_in, state[SR_W-1:1]};
  endfunction

  // States in which the encoder takes information bits from upstream
  function automatic logic accepts_input(input enc_state_t st);
    return (st == ST_IDLE) || (st == ST_ENC);
  endfunction

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder
// Purpose  : Rate-1/2, K=3 (g0=7, g1=5) convolutional encoder with
//            valid/ready handshakes on both sides and two zero tail bits
//            appended to every frame to return the trellis to state 00.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_data,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_valid,
  output logic [SYM_W-1:0] o_code,
  output logic             o_last,
  input  logic             i_ready,
  output logic             o_busy
);

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [SR_W-1:0]  r_sr;

  logic             r_valid;
  logic [SYM_W-1:0] r_code;
  logic             r_last;
  logic             r_busy;

  logic             w_out_free;   // output register empty or draining now
  logic             w_out_xfer;   // symbol handed downstream this cycle
  logic             w_ready;
  logic             w_in_xfer;    // information bit taken this cycle
  logic             w_tail_emit;  // tail symbol produced this cycle
  logic             w_emit;       // output register loads a new symbol
  logic             w_emit_bit;   // bit driving the trellis this cycle
  logic             w_emit_last;

  assign w_out_free = !r_valid || i_ready;
  assign w_out_xfer = r_valid && i_ready;

  // Next-state and handshake decode; the output register only ever loads
  // when it is free, so a held symbol can never be overwritten.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_in_xfer   = 1'b0;
    w_tail_emit = 1'b0;
    w_emit_last = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_ENC: begin
        w_ready   = accepts_input(r_state) && w_out_free;
        w_in_xfer = i_valid && w_ready;
        if (w_in_xfer) begin
          w_state_nxt = i_last ? ST_TAIL1 : ST_ENC;
        end
      end
      ST_TAIL1: begin
        w_tail_emit = w_out_free;
        if (w_out_free) begin
          w_state_nxt = ST_TAIL2;
        end
      end
      ST_TAIL2: begin
        w_tail_emit = w_out_free;
        w_emit_last = w_out_free;
        if (w_out_free) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Tail symbols are the encoding of a forced zero bit
  assign w_emit     = w_in_xfer || w_tail_emit;
  assign w_emit_bit = w_in_xfer ? i_data : 1'b0;

  // Control state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Trellis state advances once per produced symbol; two zero tail bits
  // flush it back to 00 by the time the frame closes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= SR_ZERO;
    end else if (w_emit) begin
      r_sr <= next_sr(w_emit_bit, r_sr);
    end
  end

  // Output symbol register: load on emit, drop valid after an unrefilled
  // transfer, otherwise hold everything stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_last  <= 1'b0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_code  <= branch_out(w_emit_bit, r_sr);
      r_last  <= w_emit_last;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // Frame activity flag: a fresh bit (which can only start a frame from
  // IDLE on the o_last transfer cycle) takes priority over the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
    end else if (w_in_xfer) begin
      r_busy <= 1'b1;
    end else if (w_out_xfer && r_last) begin
      r_busy <= 1'b0;
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_code  = r_code;
  assign o_last  = r_last;
  assign o_busy  = r_busy;

endmodule : conv_encoder
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder
// Purpose  : Scoreboard bench for conv_encoder. Expected symbols come from a
//            polynomial model of the code over the zero-padded frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, i_data, i_last, i_ready;
  logic       o_ready, o_valid, o_last, o_busy;
  logic [1:0] o_code;

  // kind: 0 data, 1 final data, 2 first tail, 3 second tail
  typedef struct {
    logic [1:0] code;
    int         kind;
  } exp_t;

  exp_t q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   ready_mode = 0;
  int   hold_left  = 0;

  conv_encoder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_code  (o_code),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Advance to just after the next rising edge and update downstream ready
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: i_ready = 1'b1;
      1: i_ready = ($urandom_range(0, 3) != 0);
      2: i_ready = 1'b0;
      3: begin
        if (o_valid && o_code == 2'b10 && hold_left > 0) begin
          i_ready = 1'b0;
          hold_left--;
        end else begin
          i_ready = 1'b1;
        end
      end
      default: i_ready = 1'b1;
    endcase
  endtask

  // Frame bit k, with zeros before the frame and after its end
  function automatic logic at(input logic [63:0] bits, input int n, input int k);
    return (k >= 0 && k < n) ? bits[k] : 1'b0;
  endfunction

  task automatic send_frame(input int n, input logic [63:0] bits, input int valid_pct);
    logic [1:0] syms[66];
    exp_t       e;
    int         idx;
    int         guard;
    logic       pend;
    logic [1:0] pend_code;
    step();
    // c0 = b[i]+b[i-1]+b[i-2], c1 = b[i]+b[i-2] over the frame plus two zeros
    for (int i = 0; i < n + 2; i++) begin
      logic a0, a1, a2;
      a0 = at(bits, n, i);
      a1 = at(bits, n, i - 1);
      a2 = at(bits, n, i - 2);
      e.code = {a0 ^ a1 ^ a2, a0 ^ a2};
      e.kind = (i < n - 1) ? 0 : (i == n - 1) ? 1 : (i == n) ? 2 : 3;
      syms[i] = e.code;
      q.push_back(e);
    end
    idx   = 0;
    guard = 0;
    pend  = 1'b0;
    pend_code = 2'b00;
    while (idx < n && guard < 5000) begin
      if ($urandom_range(1, 100) <= valid_pct) begin
        i_valid = 1'b1;
        i_data  = bits[idx];
        i_last  = (idx == n - 1);
      end else begin
        i_valid = 1'b0;
        i_data  = 1'($urandom_range(0, 1));
        i_last  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (pend) begin
        check("latency_valid", 8'(o_valid), 8'd1);
        check("latency_code", 8'(o_code), 8'(pend_code));
        pend = 1'b0;
      end
      if (i_valid && o_ready) begin
        pend      = 1'b1;
        pend_code = syms[idx];
        idx++;
      end
      step();
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      failures++;
      $display("FAIL frame_accept_timeout: accepted %0d of %0d bits", idx, n);
    end
    i_valid = 1'b0;
    i_data  = 1'b0;
    i_last  = 1'b0;
    @(negedge clk);
    if (pend) begin
      check("latency_valid", 8'(o_valid), 8'd1);
      check("latency_code", 8'(o_code), 8'(pend_code));
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (g < 3000) begin
      step();
      @(negedge clk);
      if (!o_valid && !o_busy && q.size() == 0) break;
      g++;
    end
    if (g >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: queue=%0d valid=%b busy=%b", q.size(), o_valid, o_busy);
    end
  endtask

  // Monitor: handshake rules, stall stability and scoreboard compare
  initial begin
    logic       sp;
    logic [1:0] hc;
    logic       hl;
    sp = 1'b0;
    hc = 2'b00;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        q.delete();
        sp = 1'b0;
      end else begin
        if (o_valid) begin
          check("busy_while_valid", 8'(o_busy), 8'd1);
          if (q.size() != 0) begin
            logic er;
            er = (q[0].kind == 0 || q[0].kind == 3) ? i_ready : 1'b0;
            check("ready_rule", 8'(o_ready), 8'(er));
          end
        end else begin
          check("ready_when_empty", 8'(o_ready), 8'd1);
        end
        if (sp) begin
          check("stall_valid", 8'(o_valid), 8'd1);
          check("stall_code", 8'(o_code), 8'(hc));
          check("stall_last", 8'(o_last), 8'(hl));
        end
        if (o_valid && i_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_symbol: got code %b last %b, none expected", o_code, o_last);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("symbol_code", 8'(o_code), 8'(e.code));
            check("symbol_last", 8'(o_last), 8'(e.kind == 3));
          end
        end
        sp = o_valid && !i_ready;
        hc = o_code;
        hl = o_last;
      end
    end
  end

  // Stimulus
  initial begin
    int          n;
    int          vp;
    logic [63:0] b;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 8'(o_valid), 8'd0);
    check("reset_code", 8'(o_code), 8'd0);
    check("reset_last", 8'(o_last), 8'd0);
    check("reset_busy", 8'(o_busy), 8'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 8'(o_ready), 8'd1);

    // Frame 1,0,1,1 with free-running downstream: 11,10,00,01,01,11
    ready_mode = 0;
    send_frame(4, 64'b1101, 100);
    drain();
    check("busy_after_frame", 8'(o_busy), 8'd0);
    check("ready_after_frame", 8'(o_ready), 8'd1);

    // Same frame, downstream stalls three cycles on the 10 symbol
    ready_mode = 3;
    hold_left  = 3;
    send_frame(4, 64'b1101, 100);
    drain();

    // Single-bit frame: 11,10,11
    ready_mode = 0;
    send_frame(1, 64'b1, 100);
    drain();

    // Reset while the first tail is pending, then restart from state 00
    ready_mode = 2;
    send_frame(1, 64'b1, 100);
    repeat (2) step();
    @(negedge clk);
    check("ready_in_tail1", 8'(o_ready), 8'd0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_valid", 8'(o_valid), 8'd0);
    check("midreset_last", 8'(o_last), 8'd0);
    check("midreset_busy", 8'(o_busy), 8'd0);
    step();
    rst_n      = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    check("ready_after_midreset", 8'(o_ready), 8'd1);
    send_frame(1, 64'b1, 100);
    drain();

    // Random frames back-to-back with random valid and ready
    repeat (40) begin
      n  = int'($urandom_range(1, 64));
      b  = {$urandom, $urandom};
      vp = int'($urandom_range(30, 100));
      ready_mode = int'($urandom_range(0, 1));
      send_frame(n, b, vp);
    end
    drain();
    check("busy_at_end", 8'(o_busy), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_conv_encoder
`default_nettype wire
